// File: rtl/adc_capture_buf_if.sv
// AXI4-stream beat channel from the ADC into the capture buffer.
// The master drives data/valid and the slave answers with ready.
interface adc_capture_buf_if #(
  parameter int DW = 128
);
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;

  modport master (output s_tdata, output s_tvalid, input  s_tready);
  modport slave  (input  s_tdata, input  s_tvalid, output s_tready);
endinterface

// File: rtl/adc_capture_buf.sv
// Triggered fixed-length ADC capture into a to-host BRAM. Each 128-bit beat
// is split into two 64-bit BRAM writes, low half first.
module adc_capture_buf #(
  parameter int AXIS_DW = 128,
  parameter int BRAM_DW = 64,
  parameter int BRAM_AW = 13,
  parameter int DROP_W  = 16
) (
  input  logic                dspclk,
  input  logic                dspreset,
  adc_capture_buf_if.slave    axis,
  input  logic                arm,
  input  logic                trig,
  input  logic                abort,
  input  logic [BRAM_AW-1:0]  length,
  output logic [BRAM_AW-1:0]  bram_addr,
  output logic [BRAM_DW-1:0]  bram_din,
  output logic                bram_we,
  output logic                busy,
  output logic                done,
  output logic [DROP_W-1:0]   drop_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  localparam logic [BRAM_AW:0]   WL_ZERO  = '0;
  localparam logic [BRAM_AW:0]   WL_ONE   = (BRAM_AW+1)'(1);
  localparam logic [BRAM_AW:0]   WL_FULL  = {1'b1, {BRAM_AW{1'b0}}};
  localparam logic [BRAM_AW-1:0] ADDR_ONE = BRAM_AW'(1);
  localparam logic [DROP_W-1:0]  DROP_ONE = DROP_W'(1);

  state_t               state;
  logic                 phase;       // high half of the last beat still to be written
  logic [BRAM_AW:0]     words_left;  // one extra bit so length=0 can mean 2^BRAM_AW
  logic [BRAM_AW-1:0]   addr_cnt;
  logic [BRAM_DW-1:0]   hi_hold;
  logic                 accept;

  assign axis.s_tready = (state == CAPTURE) && !phase && (words_left != WL_ZERO);
  assign accept        = axis.s_tvalid && axis.s_tready;

  always_ff @(posedge dspclk) begin
    if (dspreset) begin
      state      <= IDLE;
      phase      <= 1'b0;
      words_left <= WL_ZERO;
      addr_cnt   <= '0;
      hi_hold    <= '0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      // NOTE: bram_we defaults low every cycle so it is a single-cycle strobe;
      // bram_addr/bram_din are only loaded alongside it and otherwise hold.
      bram_we <= 1'b0;
      if (abort) begin
        state <= IDLE;
        phase <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (arm) begin
              state      <= ARMED;
              words_left <= (length == '0) ? WL_FULL : {1'b0, length};
              drop_cnt   <= '0;
              busy       <= 1'b1;
              done       <= 1'b0;
            end
          end
          ARMED: begin
            if (trig) begin
              state    <= CAPTURE;
              addr_cnt <= '0;
            end
          end
          CAPTURE: begin
            if (axis.s_tvalid && !axis.s_tready && (drop_cnt != '1))
              drop_cnt <= drop_cnt + DROP_ONE;
            if (accept) begin
              bram_we    <= 1'b1;
              bram_din   <= axis.s_tdata[BRAM_DW-1:0];
              bram_addr  <= addr_cnt;
              addr_cnt   <= addr_cnt + ADDR_ONE;
              words_left <= words_left - WL_ONE;
              hi_hold    <= axis.s_tdata[AXIS_DW-1:BRAM_DW];
              // With an odd length the final beat's high half is simply dropped.
              phase      <= (words_left > WL_ONE);
            end else if (phase) begin
              bram_we    <= 1'b1;
              bram_din   <= hi_hold;
              bram_addr  <= addr_cnt;
              addr_cnt   <= addr_cnt + ADDR_ONE;
              words_left <= words_left - WL_ONE;
              phase      <= 1'b0;
            end else if (words_left == WL_ZERO) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
